// File: rtl/bht_pkg.sv
// Shared types and counter helpers for the branch history table.
// Counters are handled as 4-bit values so one function serves every CTR_W.
package bht_pkg;

  typedef enum logic {
    INIT,
    READY
  } state_t;

  localparam int unsigned CTR_MAX_W = 4;

  function automatic logic [3:0] sat_next(
    input logic [3:0]  ctr,
    input logic        taken,
    input int unsigned width
  );
    logic [3:0] cmax;
    cmax = 4'((5'd1 << width) - 5'd1);
    if (taken) begin
      sat_next = (ctr < cmax) ? ctr + 4'd1 : ctr;
    end else begin
      sat_next = (ctr != 4'd0) ? ctr - 4'd1 : ctr;
    end
  endfunction

  function automatic logic [3:0] weak_nt(
    input int unsigned width
  );
    weak_nt = 4'((5'd1 << (width - 1)) - 5'd1);
  endfunction

endpackage

// File: rtl/bht_sat_ctr.sv
// Next-value logic for one saturating counter.
// Shared by the table write port and the lookup bypass.
module bht_sat_ctr
  import bht_pkg::*;
#(
  parameter int CTR_W = 2
) (
  input  logic [CTR_W-1:0] ctr,
  input  logic             taken,
  output logic [CTR_W-1:0] nxt
);

  assign nxt = CTR_W'(sat_next(4'(ctr), taken, CTR_W));

endmodule

// File: rtl/bht_predictor.sv
// Branch history table with saturating counters, bimodal or gshare indexed.
// Lookup is registered; resolve trains the table, history and statistics.
module bht_predictor
  import bht_pkg::*;
#(
  parameter int IDX_W  = 10,
  parameter int CTR_W  = 2,
  parameter int GHR_W  = 0,
  parameter int PC_LSB = 2,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  output logic              init_done,
  input  logic              lk_valid,
  input  logic [31:0]       lk_pc,
  output logic              lk_out_valid,
  output logic              lk_taken,
  output logic [CTR_W-1:0]  lk_ctr,
  output logic [IDX_W-1:0]  lk_idx,
  input  logic              up_valid,
  input  logic [IDX_W-1:0]  up_idx,
  input  logic              up_taken,
  input  logic              up_pred,
  output logic [STAT_W-1:0] stat_lookups,
  output logic [STAT_W-1:0] stat_mispred
);

  localparam int DEPTH = 1 << IDX_W;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);
  localparam logic [CTR_W-1:0] WNT = CTR_W'(weak_nt(CTR_W));
  localparam logic [STAT_W-1:0] SMAX = '1;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] pidx;
  logic [IDX_W-1:0] idx;
  logic [CTR_W-1:0] mem [DEPTH];
  logic [CTR_W-1:0] up_cur;
  logic [CTR_W-1:0] up_nxt;
  logic [CTR_W-1:0] rd_ctr;
  logic             ready;
  logic             lk_go;
  logic             up_go;
  logic             hit;

  assign ready = (state == READY);
  assign lk_go = ready && lk_valid;
  assign up_go = ready && up_valid;
  assign pidx  = lk_pc[PC_LSB +: IDX_W];

  if (GHR_W > 0) begin : g_gshare
    logic [GHR_W-1:0] ghr;

    // Shift resolved outcomes into history; lookups see the old value.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        ghr <= '0;
      end else if (up_go) begin
        ghr <= GHR_W'({ghr, up_taken});
      end
    end

    assign idx = pidx ^ IDX_W'(ghr);
  end else begin : g_bimodal
    assign idx = pidx;
  end

  assign up_cur = mem[up_idx];

  bht_sat_ctr #(
    .CTR_W(CTR_W)
  ) u_sat (
    .ctr  (up_cur),
    .taken(up_taken),
    .nxt  (up_nxt)
  );

  // A lookup hitting the entry being trained sees the trained value.
  assign hit    = up_valid && (up_idx == idx);
  assign rd_ctr = hit ? up_nxt : mem[idx];

  // Sweep every entry to weak not-taken, then stay ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= INIT;
      ptr       <= '0;
      init_done <= 1'b0;
    end else if (state == INIT) begin
      ptr <= ptr + IDX_W'(1);
      if (ptr == LAST) begin
        state     <= READY;
        init_done <= 1'b1;
      end
    end
  end

  // Table storage: sweep writes first, then resolve writes.
  always_ff @(posedge clk) begin
    if (!ready) begin
      mem[ptr] <= WNT;
    end else if (up_valid) begin
      mem[up_idx] <= up_nxt;
    end
  end

  // Registered lookup result; data holds when no lookup is made.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lk_out_valid <= 1'b0;
      lk_taken     <= 1'b0;
      lk_ctr       <= '0;
      lk_idx       <= '0;
    end else begin
      lk_out_valid <= lk_go;
      if (lk_go) begin
        lk_taken <= rd_ctr[CTR_W-1];
        lk_ctr   <= rd_ctr;
        lk_idx   <= idx;
      end
    end
  end

  // Saturating lookup and misprediction counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_lookups <= '0;
      stat_mispred <= '0;
    end else begin
      if (lk_go && stat_lookups != SMAX) begin
        stat_lookups <= stat_lookups + STAT_W'(1);
      end
      if (up_go && (up_pred != up_taken) && stat_mispred != SMAX) begin
        stat_mispred <= stat_mispred + STAT_W'(1);
      end
    end
  end

endmodule

// File: doc/bht_predictor.md
Name: bht_predictor

Overview:
Parametrised branch history table with per-entry saturating counters, the next generation of the team's 2-bit BHT/predictor pair. Each table entry holds a CTR_W-bit saturating counter. The index is taken from PC bits, XORed with a global history register when GHR_W>0 (gshare mode) and used directly when GHR_W=0 (bimodal mode). The block sits beside fetch: a registered lookup port returns a prediction, and a resolve port from execute trains the table, shifts history and counts mispredictions.

Parameters:
IDX_W, 10, table index width; the table has 2**IDX_W entries.
CTR_W, 2, counter width; legal range 1..4.
GHR_W, 0, global history length; 0 selects bimodal, 1..IDX_W selects gshare.
PC_LSB, 2, lowest PC bit used for indexing.
STAT_W, 16, width of the statistics counters.

Ports:
clk  in  1  clock; all state changes on posedge.
reset  in  1  asynchronous, active-high reset.
init_done  out  1  high once the table sweep has completed.
lk_valid  in  1  lookup request.
lk_pc  in  32  branch PC for the lookup.
lk_out_valid  out  1  lookup result valid, one cycle after the request.
lk_taken  out  1  prediction; equals the MSB of lk_ctr.
lk_ctr  out  CTR_W  counter value returned by the lookup.
lk_idx  out  IDX_W  index used by the lookup; execute returns it on up_idx.
up_valid  in  1  resolve/update request.
up_idx  in  IDX_W  index returned from the lookup.
up_taken  in  1  actual branch outcome.
up_pred  in  1  prediction that was made for this branch.
stat_lookups  out  STAT_W  accepted lookups, saturating.
stat_mispred  out  STAT_W  updates with up_pred != up_taken, saturating.

Behaviour:
- Constants: CMAX = 2**CTR_W-1; WNT (weak not-taken) = 2**(CTR_W-1)-1, i.e. 01 for CTR_W=2.
- Reset (async assert) clears:
  - outputs: init_done, lk_out_valid, lk_taken, lk_ctr, lk_idx, stat_lookups, stat_mispred all 0;
  - internal: ghr=0, sweep pointer=0, FSM state=INIT.
- FSM INIT:
  - Writes WNT to entry[ptr] and increments ptr every cycle.
  - After the write to entry 2**IDX_W-1: state becomes READY and init_done=1 on the next cycle. The sweep takes exactly 2**IDX_W cycles after reset deasserts.
  - lk_valid and up_valid are ignored in INIT; lk_out_valid stays 0 and no statistics change.
- Reset asserted mid-sweep returns the FSM to INIT with ptr=0 and restarts the sweep from 0.
- READY is terminal until the next reset.
- Index:
  - pidx = lk_pc[PC_LSB+IDX_W-1 : PC_LSB].
  - Gshare: idx = pidx XOR zero-extended ghr. Bimodal: idx = pidx.
- Lookup (READY, lk_valid=1): on the next cycle lk_out_valid=1, lk_idx=idx, lk_ctr=entry[idx], lk_taken=lk_ctr[CTR_W-1], and stat_lookups increments.
- lk_valid=0: lk_out_valid=0 next cycle; lk_taken, lk_ctr and lk_idx hold their previous values.
- Update (READY, up_valid=1), applied at the posedge:
  - up_taken=1 and entry<CMAX: entry+1. up_taken=0 and entry>0: entry-1. Otherwise the entry holds (saturation).
  - Gshare only: ghr <= {ghr[GHR_W-2:0], up_taken}.
  - stat_mispred increments if up_pred != up_taken.
- Same-cycle lookup and update to the same index: lookup returns the post-update counter (write-first bypass).
- Same-cycle GHR: the lookup index uses the pre-shift ghr.
- Different indices in the same cycle: the lookup and update are fully independent.
- Statistics counters stick at 2**STAT_W-1 and never wrap.
- Table storage is an unreset register array, initialised only by the sweep. No X may reach the outputs after init_done.

Decomposition:
- Shared package bht_pkg holds:
  - FSM state enum {INIT, READY};
  - function sat_next(ctr, taken, width);
  - function weak_nt(width).
- Sub-module bht_sat_ctr: combinational next-counter logic, instantiated on the update path and reused by the bypass comparison.
- The top holds the array, FSM, GHR and statistics.

Test Plan:
- Reset, then count cycles with IDX_W=4 -> init_done rises after exactly 16 cycles; lookups of all PCs then return lk_ctr=01, lk_taken=0.
- Bimodal, idx 5: three updates taken, then lookup -> lk_ctr 10, 11, 11 (saturated), lk_taken=1; then four not-taken updates -> 00, stays 00.
- Lookup and up_valid to idx 9 (ctr 01, taken) in the same cycle -> lk_ctr=10, lk_taken=1; a different index in the same cycle is unaffected.
- Gshare GHR_W=4: updates taken,taken,not,taken -> ghr=1101; lookup with pidx=0x003 -> lk_idx=0x00E.
- Assert reset at sweep pointer 7 -> outputs clear immediately, init_done=0, and the sweep restarts from 0 taking the full 2**IDX_W cycles.
- STAT_W=3: eight mispredicting updates -> stat_mispred=7 and holds there; lookups during INIT leave stat_lookups=0.
